stencil_rect_fill: RTL
======================

STENCIL_RECT_FILL -- requirements
Module: stencil_rect_fill

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 nRst  in  1  asynchronous active-low reset.
REQ-003 i_start  in  1  one-cycle request to fill a rectangle; sampled only in IDLE.
REQ-004 i_x0 in 10, i_y0 in 9  top-left pixel of the rectangle, in VRAM coordinates.
REQ-005 i_w in 11 (1..1024), i_h in 10 (1..512)  rectangle size in pixels; 0 is illegal.
REQ-006 i_value  in  1  mask bit to write, replicated to all 16 pixels.
REQ-007 i_hold  in  1  arbiter stall; no write is issued and no state advances while high.
REQ-008 o_fullMode  out  1  constant 1 while busy, 0 otherwise.
REQ-009 o_stencilWriteSig  out  1  write strobe to the stencil cache.
REQ-010 o_stencilWriteAdr  out  15  block address {y[8:0], xblk[5:0]}.
REQ-011 o_writeValue16 out 16, o_writeMask16 out 16  full-mode data and per-pixel mask (bit n = pixel x%16==n).
REQ-012 o_busy  out  1  high from the accepting cycle until o_done.
REQ-013 o_done  out  1  one-cycle pulse after the last write.

Function
REQ-014 FSM states: IDLE, SETUP, WRITE, DONE.
REQ-015 IDLE->SETUP on i_start; latch all inputs; o_busy rises in the next cycle.
REQ-016 SETUP (1 cycle) computes blocksPerRow = ((x0[3:0]+w-1)>>4)+1 (7 bits, range 1..65), the first mask (bits >= x0[3:0]) and the last mask (bits <= (x0+w-1)[3:0]).
REQ-017 WRITE issues exactly one write per cycle in which i_hold=0; the first write is visible at i_start+2 cycles when i_hold=0.
REQ-018 o_stencilWriteSig = writePending & !i_hold, gated combinationally; address, value and mask are registered and held stable during a hold.
REQ-019 Row walk: xblk starts at x0[9:4] and increments mod 64; the row ends after blocksPerRow writes.
REQ-020 Row walk, next row: y increments mod 512 and xblk reloads.
REQ-021 Mask per block: first block uses the first mask, last block uses the last mask, a single-block row uses first AND last, and all other blocks use 16'hFFFF.
REQ-022 Wrap case: when x0=8 and w=1024, 65 blocks are written; block index x0[9:4] appears twice, first with mask FF00 and last with mask 00FF.
REQ-023 o_writeValue16 = {16{value}}.
REQ-024 After h rows, WRITE->DONE; DONE asserts o_done for 1 cycle, deasserts o_busy, then enters IDLE.
REQ-025 Total writes = h*blocksPerRow, which is never zero.
REQ-026 i_start while not IDLE is ignored (no queueing).
REQ-027 i_start in the same cycle as o_done is ignored; the next accept is possible one cycle later.

Reset
REQ-028 nRst low forces IDLE immediately, with all outputs 0 (o_fullMode, o_stencilWriteSig, o_busy, o_done, address, value, mask).
REQ-029 Reset mid-WRITE abandons the fill with no o_done; partial writes are not undone.

Configuration
REQ-030 With STENCIL_RECT_FILL_ABORT_EN defined: add input i_abort (1 bit). i_abort high in SETUP or WRITE suppresses further writes from the next edge, moves to DONE, and pulses o_done.
REQ-031 With STENCIL_RECT_FILL_ABORT_EN undefined: no i_abort port, and every fill runs to completion.

Structure
REQ-032 A shared GPU package holds the VRAM width/height constants (1024/512), the block width (16), and the FSM state enum.
REQ-033 One sub-module, stencil_edge_mask, maps a 4-bit start and a 4-bit end to a 16-bit mask (combinational); it is instantiated twice.

Verification
REQ-034 x0=0,y0=0,w=16,h=1,value=1 -> one write, adr 0, mask FFFF, value FFFF, o_done at cycle 3 after start.
REQ-035 x0=5,y0=3,w=20,h=2 -> writes at adr {3,0} mask FFE0, {3,1} mask 01FF, {4,0} mask FFE0, {4,1} mask 01FF.
REQ-036 x0=1016,y0=511,w=16,h=2 -> xblk 63 then 0 (mask FF00/00FF); y wraps 511->0; 4 writes total.
REQ-037 x0=8,w=1024,h=1 -> 65 writes; the first and last are both at xblk 0, with masks FF00 and 00FF respectively.
REQ-038 Pulse i_hold for 3 cycles mid-row -> o_stencilWriteSig low, address stable for those 3 cycles, and no write lost or duplicated.
REQ-039 Assert nRst in the 2nd write cycle -> all outputs 0 at once; a new i_start then runs normally; with the ABORT macro defined, i_abort yields o_done with no further writes.

Source files
------------

// File: rtl/stencil_rect_fill_pkg.sv
`default_nettype none
// ============================================================================
// stencil_rect_fill_pkg : shared VRAM geometry, fill FSM states and helpers.
// Revision: 1.0
// ============================================================================
package stencil_rect_fill_pkg;

  localparam int VRAM_WIDTH  = 1024;
  localparam int VRAM_HEIGHT = 512;
  localparam int BLOCK_WIDTH = 16;

  localparam int XBLK_BITS = $clog2(VRAM_WIDTH / BLOCK_WIDTH);
  localparam int Y_BITS    = $clog2(VRAM_HEIGHT);
  localparam int ADR_BITS  = Y_BITS + XBLK_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } fillState_t;

  // A row that fits in one block needs both edges trimmed.
  function automatic logic [BLOCK_WIDTH-1:0] rowStartMask(
    input logic [6:0]             bpr,
    input logic [BLOCK_WIDTH-1:0] firstMask,
    input logic [BLOCK_WIDTH-1:0] lastMask
  );
    return (bpr == 7'd1) ? (firstMask & lastMask) : firstMask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stencil_rect_fill_edge_mask.sv
`default_nettype none
// ============================================================================
// stencil_edge_mask : 16-bit mask with bits startBit..endBit (inclusive) set.
// Revision: 1.0
// ============================================================================
module stencil_edge_mask
  import stencil_rect_fill_pkg::*;
(
  input  logic [3:0]             startBit,
  input  logic [3:0]             endBit,
  output logic [BLOCK_WIDTH-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int n = 0; n < BLOCK_WIDTH; n++) begin
      mask[n] = (5'(n) >= {1'b0, startBit}) && (5'(n) <= {1'b0, endBit});
    end
  end

endmodule
`default_nettype wire

// File: rtl/stencil_rect_fill.sv
`default_nettype none
// ============================================================================
// stencil_rect_fill : walks a rectangle in 16-pixel stencil blocks and issues
//   full-mode masked writes. Optional abort input: STENCIL_RECT_FILL_ABORT_EN.
// Revision: 1.0
// ============================================================================
module stencil_rect_fill
  import stencil_rect_fill_pkg::*;
(
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   i_start,
  input  logic [9:0]             i_x0,
  input  logic [8:0]             i_y0,
  input  logic [10:0]            i_w,
  input  logic [9:0]             i_h,
  input  logic                   i_value,
  input  logic                   i_hold,
`ifdef STENCIL_RECT_FILL_ABORT_EN
  input  logic                   i_abort,
`endif
  output logic                   o_fullMode,
  output logic                   o_stencilWriteSig,
  output logic [ADR_BITS-1:0]    o_stencilWriteAdr,
  output logic [BLOCK_WIDTH-1:0] o_writeValue16,
  output logic [BLOCK_WIDTH-1:0] o_writeMask16,
  output logic                   o_busy,
  output logic                   o_done
);

  fillState_t             r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pending;
  logic [ADR_BITS-1:0]    r_adr;
  logic [BLOCK_WIDTH-1:0] r_mask;
  logic [BLOCK_WIDTH-1:0] r_value16;

  logic [9:0]             r_x0;
  logic [8:0]             r_y0;
  logic [10:0]            r_w;
  logic [9:0]             r_h;
  logic                   r_value;

  logic [6:0]             r_bpr;
  logic [BLOCK_WIDTH-1:0] r_firstMask;
  logic [BLOCK_WIDTH-1:0] r_lastMask;
  logic [6:0]             r_blkIdx;
  logic [9:0]             r_rowIdx;

  logic [10:0]            w_span;
  logic [6:0]             w_bpr;
  logic [BLOCK_WIDTH-1:0] w_firstMask;
  logic [BLOCK_WIDTH-1:0] w_lastMask;
  logic                   w_rowEnd;
  logic                   w_nextIsLast;
  logic                   w_fillEnd;
  logic                   w_abort;

`ifdef STENCIL_RECT_FILL_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Offset of the last pixel measured from the first block's left edge.
  assign w_span = {7'd0, r_x0[3:0]} + r_w - 11'd1;
  assign w_bpr  = w_span[10:4] + 7'd1;

  stencil_edge_mask u_firstMask (
    .startBit (r_x0[3:0]),
    .endBit   (4'd15),
    .mask     (w_firstMask)
  );

  stencil_edge_mask u_lastMask (
    .startBit (4'd0),
    .endBit   (w_span[3:0]),
    .mask     (w_lastMask)
  );

  assign w_rowEnd     = (r_blkIdx == r_bpr - 7'd1);
  assign w_nextIsLast = (r_blkIdx + 7'd2 == r_bpr);
  assign w_fillEnd    = (r_rowIdx == r_h - 10'd1);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pending   <= 1'b0;
      r_adr       <= '0;
      r_mask      <= '0;
      r_value16   <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_value     <= 1'b0;
      r_bpr       <= '0;
      r_firstMask <= '0;
      r_lastMask  <= '0;
      r_blkIdx    <= '0;
      r_rowIdx    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_x0    <= i_x0;
            r_y0    <= i_y0;
            r_w     <= i_w;
            r_h     <= i_h;
            r_value <= i_value;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (!i_hold) begin
            r_bpr       <= w_bpr;
            r_firstMask <= w_firstMask;
            r_lastMask  <= w_lastMask;
            r_blkIdx    <= '0;
            r_rowIdx    <= '0;
            r_adr       <= {r_y0, r_x0[9:4]};
            r_mask      <= rowStartMask(w_bpr, w_firstMask, w_lastMask);
            r_value16   <= {BLOCK_WIDTH{r_value}};
            r_pending   <= 1'b1;
            r_state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_abort) begin
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (!i_hold) begin
            if (!w_rowEnd) begin
              r_blkIdx                <= r_blkIdx + 7'd1;
              r_adr[XBLK_BITS-1:0]    <= r_adr[XBLK_BITS-1:0] + 6'd1;
              r_mask                  <= w_nextIsLast ? r_lastMask : {BLOCK_WIDTH{1'b1}};
            end else if (w_fillEnd) begin
              r_pending <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              // Next row: y wraps at the VRAM height, x restarts at x0's block.
              r_rowIdx <= r_rowIdx + 10'd1;
              r_blkIdx <= '0;
              r_adr    <= {r_adr[ADR_BITS-1:XBLK_BITS] + 9'd1, r_x0[9:4]};
              r_mask   <= rowStartMask(r_bpr, r_firstMask, r_lastMask);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_fullMode        = r_busy;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_stencilWriteSig = r_pending & ~i_hold;
  assign o_stencilWriteAdr = r_adr;
  assign o_writeValue16    = r_value16;
  assign o_writeMask16     = r_mask;

endmodule
`default_nettype wire
